// File: rtl/cp0_exception_ctrl_if.sv
// Pipeline-side and CP0-side signals of the exception sequencer.
// slave = the sequencer itself; master = pipeline + CP0 environment.
interface cp0_exception_ctrl_if #(parameter int WIDTH = 32);
  logic [2:0]       irq_in;
  logic [WIDTH-1:0] pc_cur;
  logic             eret_req;
  logic             mtc0_we;
  logic [4:0]       mtc0_rd;
  logic [2:0]       mtc0_sel;
  logic [WIDTH-1:0] mtc0_data;
  logic [4:0]       mfc0_rd;
  logic [2:0]       mfc0_sel;
  logic [WIDTH-1:0] cp0_r_out;
  logic [4:0]       cp0_r_in;
  logic [4:0]       cp0_w_in;
  logic [WIDTH-1:0] cp0_din;
  logic             cp0_we;
  logic [2:0]       cp0_sel;
  logic             stall;
  logic             pc_redirect;
  logic [WIDTH-1:0] pc_target;
  logic [2:0]       pending;

  modport slave (
    input  irq_in, pc_cur, eret_req, mtc0_we, mtc0_rd, mtc0_sel, mtc0_data,
           mfc0_rd, mfc0_sel, cp0_r_out,
    output cp0_r_in, cp0_w_in, cp0_din, cp0_we, cp0_sel, stall, pc_redirect,
           pc_target, pending
  );

  modport master (
    output irq_in, pc_cur, eret_req, mtc0_we, mtc0_rd, mtc0_sel, mtc0_data,
           mfc0_rd, mfc0_sel, cp0_r_out,
    input  cp0_r_in, cp0_w_in, cp0_din, cp0_we, cp0_sel, stall, pc_redirect,
           pc_target, pending
  );
endinterface

// File: rtl/cp0_exception_ctrl.sv
// Owns the CP0 write port: forwards MTC0/MFC0 when idle, otherwise runs the
// interrupt-entry (EPC, Cause, Status, vector) and ERET (EPC read, Status, redirect) sequences.
module cp0_exception_ctrl #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] HANDLER_BASE = 32'h0000_0800,
  parameter int               VEC_SHIFT    = 4
) (
  input logic             clk,
  input logic             clr,
  cp0_exception_ctrl_if.slave bus
);
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  typedef enum logic [2:0] {
    IDLE, SAVE_EPC, SET_CAUSE, CLR_IE, VECTOR, ERET_RD, ERET_RS
  } state_e;

  state_e           state_q;
  logic [2:0]       pending_q, irq_d_q, ip_q;
  logic [1:0]       src_q;
  logic [WIDTH-1:0] epc_q, status_q, target_q;
  logic             stall_q, redir_q;

  logic [2:0]       irq_rise, irq_en;
  logic             take_irq;
  logic [1:0]       src_d;
  logic [WIDTH-1:0] vec_addr;

  assign irq_rise = bus.irq_in & ~irq_d_q;
  assign irq_en   = pending_q & status_q[10:8];
  assign take_irq = status_q[0] & (|irq_en);
  assign src_d    = irq_en[2] ? 2'd2 : (irq_en[1] ? 2'd1 : 2'd0);
  assign vec_addr = HANDLER_BASE + (WIDTH'(src_q) << VEC_SHIFT);

  logic [4:0]       r_in_d, w_in_d;
  logic [2:0]       sel_d;
  logic [WIDTH-1:0] din_d;
  logic             we_d;

  // CP0 port: passthrough in IDLE, one sequencer write per state otherwise
  always_comb begin
    r_in_d = bus.mfc0_rd;
    w_in_d = '0;
    sel_d  = '0;
    din_d  = '0;
    we_d   = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d  = bus.mtc0_we ? bus.mtc0_sel : bus.mfc0_sel;
        w_in_d = bus.mtc0_rd;
        din_d  = bus.mtc0_data;
        we_d   = bus.mtc0_we;
      end
      SAVE_EPC: begin
        w_in_d = REG_EPC;
        din_d  = epc_q;
        we_d   = 1'b1;
      end
      SET_CAUSE: begin
        w_in_d = REG_CAUSE;
        din_d  = WIDTH'({ip_q, 8'b0});
        we_d   = 1'b1;
      end
      CLR_IE: begin
        w_in_d = REG_STATUS;
        din_d  = {status_q[WIDTH-1:1], 1'b0};
        we_d   = 1'b1;
      end
      ERET_RD: r_in_d = REG_EPC;
      ERET_RS: begin
        w_in_d = REG_STATUS;
        din_d  = {status_q[WIDTH-1:1], 1'b1};
        we_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cp0_r_in    = r_in_d;
  assign bus.cp0_w_in    = w_in_d;
  assign bus.cp0_sel     = sel_d;
  assign bus.cp0_din     = din_d;
  assign bus.cp0_we      = we_d;
  assign bus.stall       = stall_q;
  assign bus.pc_redirect = redir_q;
  assign bus.pc_target   = target_q;
  assign bus.pending     = pending_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      pending_q <= '0;
      irq_d_q   <= '0;
      ip_q      <= '0;
      src_q     <= '0;
      epc_q     <= '0;
      status_q  <= '0;
      target_q  <= '0;
      stall_q   <= 1'b0;
      redir_q   <= 1'b0;
    end else begin
      irq_d_q   <= bus.irq_in;
      pending_q <= pending_q | irq_rise;
      redir_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.mtc0_we && bus.mtc0_rd == REG_STATUS && bus.mtc0_sel == 3'd0)
            status_q <= bus.mtc0_data;
          // ERET wins over an interrupt; a forwarded MTC0 defers the interrupt a cycle
          if (bus.eret_req) begin
            state_q <= ERET_RD;
            stall_q <= 1'b1;
          end else if (!bus.mtc0_we && take_irq) begin
            epc_q   <= bus.pc_cur;
            src_q   <= src_d;
            ip_q    <= pending_q;
            state_q <= SAVE_EPC;
            stall_q <= 1'b1;
          end
        end
        SAVE_EPC:  state_q <= SET_CAUSE;
        SET_CAUSE: state_q <= CLR_IE;
        CLR_IE: begin
          status_q <= {status_q[WIDTH-1:1], 1'b0};
          target_q <= vec_addr;
          redir_q  <= 1'b1;
          state_q  <= VECTOR;
        end
        VECTOR: begin
          // a fresh edge on the serviced line in this cycle must survive the clear
          pending_q <= (pending_q & ~(3'b001 << src_q)) | irq_rise;
          stall_q   <= 1'b0;
          state_q   <= IDLE;
        end
        ERET_RD: begin
          epc_q    <= bus.cp0_r_out;
          target_q <= bus.cp0_r_out;
          redir_q  <= 1'b1;
          state_q  <= ERET_RS;
        end
        ERET_RS: begin
          status_q <= {status_q[WIDTH-1:1], 1'b1};
          stall_q  <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed bench: a small CP0 register file sits behind the sequencer, and each
// scenario task checks stall/redirect timing and the values landing in CP0.
module tb_cp0_exception_ctrl;
  logic clk;
  logic clr;
  int   n_pass;
  int   n_tot;

  cp0_exception_ctrl_if #(.WIDTH(32)) bus ();

  cp0_exception_ctrl #(
    .WIDTH(32), .HANDLER_BASE(32'h0000_0800), .VEC_SHIFT(4)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  logic [31:0] cp0_regs [32];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) cp0_regs[i] <= '0;
    end else if (bus.cp0_we && bus.cp0_sel == 3'd0) begin
      cp0_regs[bus.cp0_w_in] <= bus.cp0_din;
    end
  end
  assign bus.cp0_r_out = cp0_regs[bus.cp0_r_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] rd, input logic [31:0] data);
    bus.mtc0_we   = 1'b1;
    bus.mtc0_rd   = rd;
    bus.mtc0_sel  = 3'd0;
    bus.mtc0_data = data;
    step();
    bus.mtc0_we   = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    n_tot++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got=%0h exp=0", bus.stall); else n_pass++;
    n_tot++; if (bus.pc_redirect !== 1'b0) $display("FAIL reset_redirect got=%0h exp=0", bus.pc_redirect); else n_pass++;
    n_tot++; if (bus.pc_target !== 32'h0) $display("FAIL reset_target got=%0h exp=0", bus.pc_target); else n_pass++;
    n_tot++; if (bus.pending !== 3'b000) $display("FAIL reset_pending got=%0h exp=0", bus.pending); else n_pass++;
    n_tot++; if (bus.cp0_we !== 1'b0) $display("FAIL reset_cp0_we got=%0h exp=0", bus.cp0_we); else n_pass++;
  endtask

  task automatic test_irq_single();
    int sc;
    sc = 0;
    mtc0(5'd12, 32'h0000_0201);
    bus.pc_cur = 32'h40;
    bus.irq_in = 3'b010;
    step();
    bus.irq_in = 3'b000;
    n_tot++; if (bus.pending !== 3'b010) $display("FAIL irq1_pending got=%0h exp=2", bus.pending); else n_pass++;
    n_tot++; if (bus.stall !== 1'b0) $display("FAIL irq1_pre_stall got=%0h exp=0", bus.stall); else n_pass++;
    step(); sc += int'(bus.stall);
    n_tot++; if (bus.cp0_din !== 32'h40) $display("FAIL irq1_epc_din got=%0h exp=40", bus.cp0_din); else n_pass++;
    step(); sc += int'(bus.stall);
    n_tot++; if (cp0_regs[14] !== 32'h40) $display("FAIL irq1_epc got=%0h exp=40", cp0_regs[14]); else n_pass++;
    step(); sc += int'(bus.stall);
    n_tot++; if (cp0_regs[13] !== 32'h200) $display("FAIL irq1_cause got=%0h exp=200", cp0_regs[13]); else n_pass++;
    step(); sc += int'(bus.stall);
    n_tot++; if (bus.pc_redirect !== 1'b1) $display("FAIL irq1_redirect got=%0h exp=1", bus.pc_redirect); else n_pass++;
    n_tot++; if (bus.pc_target !== 32'h810) $display("FAIL irq1_target got=%0h exp=810", bus.pc_target); else n_pass++;
    n_tot++; if (cp0_regs[12] !== 32'h200) $display("FAIL irq1_status got=%0h exp=200", cp0_regs[12]); else n_pass++;
    step(); sc += int'(bus.stall);
    n_tot++; if (sc !== 4) $display("FAIL irq1_stall_cycles got=%0d exp=4", sc); else n_pass++;
    n_tot++; if (bus.pending !== 3'b000) $display("FAIL irq1_pending_clr got=%0h exp=0", bus.pending); else n_pass++;
    n_tot++; if (bus.pc_redirect !== 1'b0) $display("FAIL irq1_redirect_off got=%0h exp=0", bus.pc_redirect); else n_pass++;
  endtask

  task automatic test_irq_priority();
    mtc0(5'd12, 32'h0000_0701);
    bus.irq_in = 3'b101;
    step();
    bus.irq_in = 3'b000;
    n_tot++; if (bus.pending !== 3'b101) $display("FAIL prio_pending got=%0h exp=5", bus.pending); else n_pass++;
    step(); step(); step();
    n_tot++; if (cp0_regs[13] !== 32'h500) $display("FAIL prio_cause got=%0h exp=500", cp0_regs[13]); else n_pass++;
    step();
    n_tot++; if (bus.pc_target !== 32'h820) $display("FAIL prio_target got=%0h exp=820", bus.pc_target); else n_pass++;
    step();
    n_tot++; if (bus.pending !== 3'b001) $display("FAIL prio_pending_left got=%0h exp=1", bus.pending); else n_pass++;
    n_tot++; if (cp0_regs[12] !== 32'h700) $display("FAIL prio_status got=%0h exp=700", cp0_regs[12]); else n_pass++;
  endtask

  task automatic test_eret();
    // irq0 stays pending but masked by IE=0 until ERET restores IE
    mtc0(5'd14, 32'h1234);
    bus.pc_cur   = 32'h200;
    bus.eret_req = 1'b1;
    step();
    bus.eret_req = 1'b0;
    n_tot++; if (bus.stall !== 1'b1) $display("FAIL eret_rd_stall got=%0h exp=1", bus.stall); else n_pass++;
    n_tot++; if (bus.cp0_r_in !== 5'd14) $display("FAIL eret_rd_reg got=%0d exp=14", bus.cp0_r_in); else n_pass++;
    step();
    n_tot++; if (bus.pc_redirect !== 1'b1 || bus.pc_target !== 32'h1234)
      $display("FAIL eret_redirect got=%0h/%0h exp=1/1234", bus.pc_redirect, bus.pc_target); else n_pass++;
    n_tot++; if (bus.stall !== 1'b1) $display("FAIL eret_rs_stall got=%0h exp=1", bus.stall); else n_pass++;
    step();
    n_tot++; if (bus.stall !== 1'b0) $display("FAIL eret_idle_stall got=%0h exp=0", bus.stall); else n_pass++;
    n_tot++; if (cp0_regs[12] !== 32'h701) $display("FAIL eret_status got=%0h exp=701", cp0_regs[12]); else n_pass++;
    step(); step(); step(); step();
    n_tot++; if (bus.pc_target !== 32'h800) $display("FAIL eret_then_irq0 got=%0h exp=800", bus.pc_target); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    mtc0(5'd14, 32'h1234);
    mtc0(5'd12, 32'h0000_0701);
    bus.irq_in = 3'b100;
    step();
    bus.irq_in   = 3'b000;
    bus.pc_cur   = 32'h300;
    bus.eret_req = 1'b1;
    step();
    bus.eret_req = 1'b0;
    n_tot++; if (bus.cp0_r_in !== 5'd14) $display("FAIL b2b_eret_first got=%0d exp=14", bus.cp0_r_in); else n_pass++;
    step();
    n_tot++; if (bus.pc_target !== 32'h1234) $display("FAIL b2b_eret_target got=%0h exp=1234", bus.pc_target); else n_pass++;
    step();
    n_tot++; if (bus.stall !== 1'b0) $display("FAIL b2b_gap got=%0h exp=0", bus.stall); else n_pass++;
    step();
    n_tot++; if (bus.stall !== 1'b1) $display("FAIL b2b_entry got=%0h exp=1", bus.stall); else n_pass++;
    step();
    n_tot++; if (cp0_regs[14] !== 32'h300) $display("FAIL b2b_epc got=%0h exp=300", cp0_regs[14]); else n_pass++;
    step(); step();
    n_tot++; if (bus.pc_redirect !== 1'b1 || bus.pc_target !== 32'h820)
      $display("FAIL b2b_vector got=%0h/%0h exp=1/820", bus.pc_redirect, bus.pc_target); else n_pass++;
    step();
  endtask

  task automatic test_irq_masked();
    bus.irq_in = 3'b100;
    step();
    bus.irq_in = 3'b000;
    step();
    n_tot++; if (bus.stall !== 1'b0) $display("FAIL masked_no_seq got=%0h exp=0", bus.stall); else n_pass++;
    n_tot++; if (bus.pending !== 3'b100) $display("FAIL masked_pending got=%0h exp=4", bus.pending); else n_pass++;
    mtc0(5'd12, 32'h0000_0401);
    step();
    n_tot++; if (bus.stall !== 1'b1) $display("FAIL unmask_entry got=%0h exp=1", bus.stall); else n_pass++;
    step(); step(); step();
    n_tot++; if (bus.pc_target !== 32'h820) $display("FAIL unmask_target got=%0h exp=820", bus.pc_target); else n_pass++;
    step();
    n_tot++; if (bus.pending !== 3'b000) $display("FAIL unmask_pending got=%0h exp=0", bus.pending); else n_pass++;
  endtask

  task automatic test_mtc0_vs_irq();
    bus.irq_in = 3'b100;
    step();
    bus.irq_in = 3'b000;
    mtc0(5'd12, 32'h0000_0401);
    bus.pc_cur = 32'h80;
    mtc0(5'd14, 32'h0000_abcd);
    n_tot++; if (bus.stall !== 1'b0) $display("FAIL mtc0_first_stall got=%0h exp=0", bus.stall); else n_pass++;
    bus.mfc0_rd  = 5'd14;
    bus.mfc0_sel = 3'd0;
    #1;
    n_tot++; if (bus.cp0_r_out !== 32'h0000_abcd) $display("FAIL mfc0_epc got=%0h exp=abcd", bus.cp0_r_out); else n_pass++;
    step();
    bus.mfc0_rd = 5'd0;
    n_tot++; if (bus.stall !== 1'b1) $display("FAIL mtc0_then_entry got=%0h exp=1", bus.stall); else n_pass++;
    step();
    n_tot++; if (cp0_regs[14] !== 32'h80) $display("FAIL mtc0_then_epc got=%0h exp=80", cp0_regs[14]); else n_pass++;
    step(); step(); step();
  endtask

  task automatic test_clr_mid();
    mtc0(5'd12, 32'h0000_0401);
    bus.irq_in = 3'b100;
    step();
    bus.irq_in = 3'b000;
    step();
    step();
    n_tot++; if (bus.stall !== 1'b1) $display("FAIL clr_pre_stall got=%0h exp=1", bus.stall); else n_pass++;
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_tot++; if (bus.stall !== 1'b0) $display("FAIL clr_stall got=%0h exp=0", bus.stall); else n_pass++;
    n_tot++; if (bus.pending !== 3'b000) $display("FAIL clr_pending got=%0h exp=0", bus.pending); else n_pass++;
    n_tot++; if (bus.pc_target !== 32'h0) $display("FAIL clr_target got=%0h exp=0", bus.pc_target); else n_pass++;
    step();
    n_tot++; if (bus.pc_redirect !== 1'b0 || bus.stall !== 1'b0)
      $display("FAIL clr_no_resume got=%0h/%0h exp=0/0", bus.pc_redirect, bus.stall); else n_pass++;
    // ERET sets only IE on top of the shadow, so Status reads back the shadow | 1
    bus.eret_req = 1'b1;
    step();
    bus.eret_req = 1'b0;
    step();
    step();
    n_tot++; if (cp0_regs[12] !== 32'h1) $display("FAIL clr_shadow got=%0h exp=1", cp0_regs[12]); else n_pass++;
  endtask

  initial begin
    n_pass        = 0;
    n_tot         = 0;
    clr           = 1'b1;
    bus.irq_in    = '0;
    bus.pc_cur    = '0;
    bus.eret_req  = 1'b0;
    bus.mtc0_we   = 1'b0;
    bus.mtc0_rd   = '0;
    bus.mtc0_sel  = '0;
    bus.mtc0_data = '0;
    bus.mfc0_rd   = '0;
    bus.mfc0_sel  = '0;
    test_reset();
    test_irq_single();
    test_irq_priority();
    test_eret();
    test_back_to_back();
    test_irq_masked();
    test_mtc0_vs_irq();
    test_clr_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
